// File: rtl/uart_mm_seq_if.sv
// uart_mm_seq_if: Avalon-MM master bus plus TX/RX byte streams and status of the UART sequencer.
interface uart_mm_seq_if;
    logic        avm_write_o;
    logic        avm_read_o;
    logic [2:0]  avm_address_o;
    logic [31:0] avm_writedata_o;
    logic [3:0]  avm_byteenable_o;
    logic        avm_waitrequest_i;
    logic [31:0] avm_readdata_i;
    logic [7:0]  tx_data_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_perr_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic        cfg_done_o;
    logic        busy_o;

    modport master (
        output avm_write_o, avm_read_o, avm_address_o, avm_writedata_o, avm_byteenable_o,
        input  avm_waitrequest_i, avm_readdata_i,
        input  tx_data_i, tx_valid_i,
        output tx_ready_o,
        output rx_data_o, rx_perr_o, rx_valid_o,
        input  rx_ready_i,
        output cfg_done_o, busy_o
    );

    modport slave (
        input  avm_write_o, avm_read_o, avm_address_o, avm_writedata_o, avm_byteenable_o,
        output avm_waitrequest_i, avm_readdata_i,
        output tx_data_i, tx_valid_i,
        input  tx_ready_o,
        input  rx_data_o, rx_perr_o, rx_valid_o,
        output rx_ready_i,
        input  cfg_done_o, busy_o
    );
endinterface

// File: rtl/uart_mm_seq.sv
// uart_mm_seq: Avalon-MM master that configures a UART, then polls status and moves one byte
// per status read between the UART FIFOs and the TX/RX byte streams.
module uart_mm_seq #(
    parameter logic [31:0] CTRL_INIT  = 32'h0000_0000,
    parameter logic [31:0] BAUD_INIT  = 32'h0000_0000,
    parameter int          RD_LATENCY = 1
) (
    input logic           clk,
    input logic           reset_n,
    uart_mm_seq_if.master bus
);
    typedef enum logic [2:0] {INIT_CTRL, INIT_BAUD, POLL, STAT_WAIT, RX_RD, RX_WAIT, TX_WR} state_t;

    state_t      state;
    logic [2:0]  lat_cnt;
    logic [7:0]  tx_hold;
    logic        tx_full;
    logic        last_rx;
    logic        accept, rx_elig, tx_elig, rx_pick;
    logic        cmd_wr, cmd_rd;
    logic [2:0]  cmd_addr;
    logic [31:0] cmd_data;

    assign bus.avm_byteenable_o = 4'hF;
    assign bus.busy_o = bus.avm_read_o | bus.avm_write_o | (lat_cnt != 3'd0);
    assign accept  = (bus.avm_read_o | bus.avm_write_o) & ~bus.avm_waitrequest_i;
    assign rx_elig = ~bus.avm_readdata_i[0] & ~bus.rx_valid_o;
    assign tx_elig = ~bus.avm_readdata_i[3] & tx_full;
    assign rx_pick = rx_elig & (~tx_elig | ~last_rx);

    // Transfer each strobe state would issue; held on the bus until accepted.
    assign cmd_wr   = state inside {INIT_CTRL, INIT_BAUD, TX_WR};
    assign cmd_rd   = state inside {POLL, RX_RD};
    assign cmd_addr = state == INIT_BAUD ? 3'd1 : state == RX_RD ? 3'd5 : state == TX_WR ? 3'd4 : 3'd0;
    assign cmd_data = state == INIT_CTRL ? CTRL_INIT : state == INIT_BAUD ? BAUD_INIT :
                      state == TX_WR ? {24'h0, tx_hold} : 32'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= INIT_CTRL;
            lat_cnt             <= 3'd0;
            tx_hold             <= 8'h0;
            tx_full             <= 1'b0;
            last_rx             <= 1'b0;
            bus.avm_write_o     <= 1'b0;
            bus.avm_read_o      <= 1'b0;
            bus.avm_address_o   <= 3'd0;
            bus.avm_writedata_o <= 32'h0;
            bus.tx_ready_o      <= 1'b0;
            bus.rx_data_o       <= 8'h0;
            bus.rx_perr_o       <= 1'b0;
            bus.rx_valid_o      <= 1'b0;
            bus.cfg_done_o      <= 1'b0;
        end else begin
            if (bus.rx_valid_o && bus.rx_ready_i) bus.rx_valid_o <= 1'b0;
            if (bus.tx_valid_i && bus.tx_ready_o) begin
                tx_hold        <= bus.tx_data_i;
                tx_full        <= 1'b1;
                bus.tx_ready_o <= 1'b0;
            end else begin
                bus.tx_ready_o <= ~tx_full;
            end
            if (!(bus.avm_read_o || bus.avm_write_o)) begin
                if (cmd_wr || cmd_rd) begin
                    bus.avm_write_o     <= cmd_wr;
                    bus.avm_read_o      <= cmd_rd;
                    bus.avm_address_o   <= cmd_addr;
                    bus.avm_writedata_o <= cmd_data;
                end
            end else if (accept) begin
                bus.avm_write_o     <= 1'b0;
                bus.avm_read_o      <= 1'b0;
                bus.avm_address_o   <= 3'd0;
                bus.avm_writedata_o <= 32'h0;
                case (state)
                    INIT_CTRL: state <= INIT_BAUD;
                    INIT_BAUD: begin
                        state          <= POLL;
                        bus.cfg_done_o <= 1'b1;
                    end
                    POLL: begin
                        state   <= STAT_WAIT;
                        lat_cnt <= 3'(RD_LATENCY);
                    end
                    RX_RD: begin
                        state   <= RX_WAIT;
                        lat_cnt <= 3'(RD_LATENCY);
                    end
                    TX_WR: begin
                        state          <= POLL;
                        tx_full        <= 1'b0;
                        bus.tx_ready_o <= 1'b1;
                    end
                    default: ;
                endcase
            end
            // Read data is taken on the last latency cycle, straight off the bus.
            if (lat_cnt != 3'd0) begin
                lat_cnt <= lat_cnt - 3'd1;
                if (lat_cnt == 3'd1) begin
                    if (state == STAT_WAIT) begin
                        state <= rx_pick ? RX_RD : tx_elig ? TX_WR : POLL;
                        if (rx_pick) last_rx <= 1'b1;
                        else if (tx_elig) last_rx <= 1'b0;
                    end else begin
                        bus.rx_data_o  <= bus.avm_readdata_i[7:0];
                        bus.rx_perr_o  <= bus.avm_readdata_i[8];
                        bus.rx_valid_o <= 1'b1;
                        state          <= POLL;
                    end
                end
            end
        end
    end
endmodule
